pacman_round_sequencer: RTL and testbench



---
 rtl/pacman_pkg.sv | 29 ++
 rtl/pacman_tick_timer.sv | 24 ++
 rtl/pacman_round_sequencer.sv | 147 ++++++++++++++
 tb/tb_pacman_round_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared Pac-Man encodings: round-sequencer states, facing-direction one-hots
// and level limits, used by the sequencer, movement and sprite blocks.
package pacman_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] READY     = 3'd1;
  localparam logic [2:0] PLAY      = 3'd2;
  localparam logic [2:0] DYING     = 3'd3;
  localparam logic [2:0] CLEAR     = 3'd4;
  localparam logic [2:0] GAME_OVER = 3'd5;

  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b1000;

  localparam logic [3:0] MAX_LEVEL = 4'd15;

  // Death spin: Pac-Man rotates right, up, left, down as the frame advances.
  function automatic logic [3:0] death_dir(input logic [1:0] frame);
    case (frame)
      2'b00:   death_dir = DIR_RIGHT;
      2'b01:   death_dir = DIR_UP;
      2'b10:   death_dir = DIR_LEFT;
      default: death_dir = DIR_DOWN;
    endcase
  endfunction

endpackage

// File: rtl/pacman_tick_timer.sv
// Animation-tick counter: cleared on phase entry, advanced by anim_tick,
// and flags when the count equals the target of the current phase.
module pacman_tick_timer
  import pacman_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_tick,
  input  logic [7:0] i_target,
  output logic       o_done
);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_count <= 8'd0;
    else if (i_clear) r_count <= 8'd0;
    else if (i_tick)  r_count <= r_count + 8'd1;
  end

  assign o_done = (r_count == i_target);

endmodule

// File: rtl/pacman_round_sequencer.sv
// Game-round controller: steps through intro, play, death, level-clear and
// game-over, tracking lives/level and issuing respawn and maze-refill pulses.
module pacman_round_sequencer
  import pacman_pkg::*;
#(
  parameter int START_LIVES  = 3,
  parameter int READY_TICKS  = 32,
  parameter int DEATH_FRAMES = 8,
  parameter int CLEAR_TICKS  = 16
) (
  input  logic       clk_50mhz,
  input  logic       reset,
  input  logic       anim_tick,
  input  logic       start_btn,
  input  logic       pacman_dead,
  input  logic       level_clear,
  output logic [2:0] game_state,
  output logic       freeze,
  output logic [1:0] lives,
  output logic [3:0] level,
  output logic [2:0] death_frame,
  output logic [3:0] pacman_cur_dir,
  output logic       round_reset,
  output logic       maze_reload
);

  logic [2:0] r_state;
  logic       r_start_q;
  logic [1:0] r_lives;
  logic [3:0] r_level;
  logic [2:0] r_death_frame;
  logic [3:0] r_dir;
  logic       r_round_reset;
  logic       r_maze_reload;

  logic [2:0] w_next_state;
  logic [7:0] w_target;
  logic       w_done;
  logic       w_start_pulse;

  assign w_start_pulse = start_btn & ~r_start_q;

  always_comb begin
    w_target = 8'hFF;
    case (r_state)
      READY:   w_target = 8'(READY_TICKS);
      DYING:   w_target = 8'(DEATH_FRAMES);
      CLEAR:   w_target = 8'(CLEAR_TICKS);
      default: w_target = 8'hFF;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, GAME_OVER: if (w_start_pulse) w_next_state = READY;
      READY:           if (w_done) w_next_state = PLAY;
      PLAY: begin
        if (pacman_dead)      w_next_state = DYING;
        else if (level_clear) w_next_state = CLEAR;
      end
      DYING:           if (w_done) w_next_state = (r_lives <= 2'd1) ? GAME_OVER : READY;
      CLEAR:           if (w_done) w_next_state = READY;
      default:         w_next_state = IDLE;
    endcase
  end

  // Clearing on every state change means a tick in the transition cycle never
  // reaches the new state's count.
  pacman_tick_timer u_timer (
    .clk      (clk_50mhz),
    .rst_n    (reset),
    .i_clear  (w_next_state != r_state),
    .i_tick   (anim_tick),
    .i_target (w_target),
    .o_done   (w_done)
  );

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_start_q     <= 1'b0;
      r_lives       <= 2'(START_LIVES);
      r_level       <= 4'd0;
      r_death_frame <= 3'd0;
      r_dir         <= DIR_RIGHT;
      r_round_reset <= 1'b0;
      r_maze_reload <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_start_q     <= start_btn;
      r_round_reset <= 1'b0;
      r_maze_reload <= 1'b0;
      case (r_state)
        IDLE, GAME_OVER: begin
          if (w_start_pulse) begin
            r_lives       <= 2'(START_LIVES);
            r_level       <= 4'd1;
            r_dir         <= DIR_RIGHT;
            r_round_reset <= 1'b1;
            r_maze_reload <= 1'b1;
          end
        end
        PLAY: begin
          if (pacman_dead) begin
            r_death_frame <= 3'd0;
            r_dir         <= death_dir(2'b00);
          end
        end
        DYING: begin
          if (w_done) begin
            // Last life goes straight to game over with no respawn.
            if (r_lives <= 2'd1) begin
              r_lives <= 2'd0;
            end else begin
              r_lives       <= r_lives - 2'd1;
              r_dir         <= DIR_RIGHT;
              r_round_reset <= 1'b1;
            end
          end else if (anim_tick) begin
            r_death_frame <= r_death_frame + 3'd1;
            r_dir         <= death_dir(r_death_frame[1:0] + 2'd1);
          end
        end
        CLEAR: begin
          if (w_done) begin
            if (r_level != MAX_LEVEL) r_level <= r_level + 4'd1;
            r_dir         <= DIR_RIGHT;
            r_round_reset <= 1'b1;
            r_maze_reload <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign game_state     = r_state;
  assign freeze         = (r_state != PLAY);
  assign lives          = r_lives;
  assign level          = r_level;
  assign death_frame    = r_death_frame;
  assign pacman_cur_dir = r_dir;
  assign round_reset    = r_round_reset;
  assign maze_reload    = r_maze_reload;

endmodule

// File: tb/tb_pacman_round_sequencer.sv
// Directed bench for the Pac-Man round sequencer with default parameters and
// an anim_tick strobe every fourth clock.
module tb_pacman_round_sequencer;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_DYING = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       anim_tick;
  logic       start_btn;
  logic       pacman_dead;
  logic       level_clear;
  logic [2:0] game_state;
  logic       freeze;
  logic [1:0] lives;
  logic [3:0] level;
  logic [2:0] death_frame;
  logic [3:0] pacman_cur_dir;
  logic       round_reset;
  logic       maze_reload;

  int total = 0;
  int bad = 0;
  int phase = 0;
  int rr_cnt = 0;
  int mr_cnt = 0;
  int rr_in_play = 0;

  pacman_round_sequencer dut (
    .clk_50mhz      (clk),
    .reset          (rst_n),
    .anim_tick      (anim_tick),
    .start_btn      (start_btn),
    .pacman_dead    (pacman_dead),
    .level_clear    (level_clear),
    .game_state     (game_state),
    .freeze         (freeze),
    .lives          (lives),
    .level          (level),
    .death_frame    (death_frame),
    .pacman_cur_dir (pacman_cur_dir),
    .round_reset    (round_reset),
    .maze_reload    (maze_reload)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (round_reset) rr_cnt++;
    if (maze_reload) mr_cnt++;
    if (round_reset && game_state == S_PLAY) rr_in_play++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    phase = phase + 1;
    anim_tick = (phase % 4 == 0);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (game_state !== s && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 32'(game_state), 32'(s));
  endtask

  task automatic die();
    int n = 0;
    pacman_dead = 1'b1;
    cyc();
    pacman_dead = 1'b0;
    while (game_state === S_DYING && n < 200) begin
      cyc();
      n++;
    end
  endtask

  task automatic clear_level();
    int n = 0;
    level_clear = 1'b1;
    cyc();
    level_clear = 1'b0;
    while (game_state === S_CLEAR && n < 200) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    int n, k, rr_base, mr_base;
    logic tn;
    logic [3:0] exp_dir [0:7];
    exp_dir[0] = 4'b0001; exp_dir[1] = 4'b0100; exp_dir[2] = 4'b0010; exp_dir[3] = 4'b1000;
    exp_dir[4] = 4'b0001; exp_dir[5] = 4'b0100; exp_dir[6] = 4'b0010; exp_dir[7] = 4'b1000;

    rst_n = 1'b0; anim_tick = 1'b0; start_btn = 1'b0; pacman_dead = 1'b0; level_clear = 1'b0;
    #12;
    chk("rst_state",  32'(game_state), 32'(S_IDLE));
    chk("rst_freeze", 32'(freeze), 32'd1);
    chk("rst_lives",  32'(lives), 32'd3);
    chk("rst_level",  32'(level), 32'd0);
    chk("rst_dir",    32'(pacman_cur_dir), 32'h1);
    chk("rst_pulses", {30'd0, round_reset, maze_reload}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk("idle_hold", 32'(game_state), 32'(S_IDLE));

    // Start held for 10 cycles: single pulse, then READY timing.
    rr_base = rr_cnt; mr_base = mr_cnt;
    start_btn = 1'b1;
    cyc();
    chk("start_ready", 32'(game_state), 32'(S_READY));
    chk("start_rr",    32'(round_reset), 32'd1);
    chk("start_lives", 32'(lives), 32'd3);
    chk("start_level", 32'(level), 32'd1);
    n = 0; k = 0;
    while (n < 32 && k < 400) begin
      tn = anim_tick;
      cyc();
      k++;
      if (k == 9) start_btn = 1'b0;
      if (tn) n++;
    end
    chk("ready_32_ticks",  32'(n), 32'd32);
    chk("ready_frozen",    32'(freeze), 32'd1);
    cyc();
    chk("play_unfrozen",   32'(freeze), 32'd0);
    chk("play_state",      32'(game_state), 32'(S_PLAY));
    chk("start_one_rr",    32'(rr_cnt - rr_base), 32'd1);
    chk("start_one_mr",    32'(mr_cnt - mr_base), 32'd1);

    // Death animation direction sweep.
    pacman_dead = 1'b1;
    cyc();
    pacman_dead = 1'b0;
    chk("dying_state", 32'(game_state), 32'(S_DYING));
    chk("dying_frame0", 32'(death_frame), 32'd0);
    chk("dying_dir0",   32'(pacman_cur_dir), 32'h1);
    rr_base = rr_cnt;
    n = 0; k = 0;
    while (n < 8 && k < 100) begin
      tn = anim_tick;
      cyc();
      k++;
      if (tn) begin
        n++;
        chk($sformatf("dying_dir_t%0d", n), 32'(pacman_cur_dir), 32'(exp_dir[n % 8]));
      end
    end
    chk("dying_still", 32'(game_state), 32'(S_DYING));
    cyc();
    chk("death1_ready", 32'(game_state), 32'(S_READY));
    chk("death1_lives", 32'(lives), 32'd2);
    chk("death1_rr",    32'(round_reset), 32'd1);
    cyc();
    chk("death1_one_rr", 32'(rr_cnt - rr_base), 32'd1);

    // Two more deaths down to game over.
    wait_state(S_PLAY, 400, "to_play_2");
    die();
    chk("death2_lives", 32'(lives), 32'd1);
    wait_state(S_PLAY, 400, "to_play_3");
    rr_base = rr_cnt;
    die();
    cyc();
    chk("over_state", 32'(game_state), 32'(S_OVER));
    chk("over_lives", 32'(lives), 32'd0);
    chk("over_no_rr", 32'(rr_cnt - rr_base), 32'd0);
    chk("over_freeze", 32'(freeze), 32'd1);
    start_btn = 1'b1;
    cyc();
    start_btn = 1'b0;
    chk("restart_state", 32'(game_state), 32'(S_READY));
    chk("restart_lives", 32'(lives), 32'd3);
    chk("restart_level", 32'(level), 32'd1);

    // Simultaneous death and clear: death wins.
    wait_state(S_PLAY, 400, "to_play_4");
    pacman_dead = 1'b1; level_clear = 1'b1;
    cyc();
    pacman_dead = 1'b0; level_clear = 1'b0;
    chk("both_dying", 32'(game_state), 32'(S_DYING));
    chk("both_level", 32'(level), 32'd1);
    wait_state(S_READY, 100, "both_to_ready");
    chk("both_lives", 32'(lives), 32'd2);

    // Lone clear: 16 ticks then level up with one maze reload.
    wait_state(S_PLAY, 400, "to_play_5");
    mr_base = mr_cnt; rr_base = rr_cnt;
    level_clear = 1'b1;
    cyc();
    level_clear = 1'b0;
    chk("clear_state", 32'(game_state), 32'(S_CLEAR));
    n = 0; k = 0;
    while (n < 16 && k < 200) begin
      tn = anim_tick;
      cyc();
      k++;
      if (tn) n++;
    end
    chk("clear_waiting", 32'(game_state), 32'(S_CLEAR));
    cyc();
    chk("clear_ready", 32'(game_state), 32'(S_READY));
    chk("clear_level", 32'(level), 32'd2);
    chk("clear_lives", 32'(lives), 32'd2);
    cyc();
    chk("clear_one_mr", 32'(mr_cnt - mr_base), 32'd1);
    chk("clear_one_rr", 32'(rr_cnt - rr_base), 32'd1);

    // Climb to level 15, then one more clear must saturate.
    k = 0;
    while (level != 4'd15 && k < 20) begin
      wait_state(S_PLAY, 400, "climb_play");
      clear_level();
      k++;
    end
    chk("level_15", 32'(level), 32'd15);
    wait_state(S_PLAY, 400, "to_play_sat");
    clear_level();
    chk("level_sat", 32'(level), 32'd15);
    chk("level_sat_state", 32'(game_state), 32'(S_READY));

    // Asynchronous reset in the middle of the death spin.
    wait_state(S_PLAY, 400, "to_play_6");
    pacman_dead = 1'b1;
    cyc();
    pacman_dead = 1'b0;
    k = 0;
    while (death_frame != 3'd5 && k < 100) begin
      cyc();
      k++;
    end
    chk("mid_frame5", 32'(death_frame), 32'd5);
    chk("mid_dir",    32'(pacman_cur_dir), 32'h4);
    #2;
    rr_base = rr_cnt; mr_base = mr_cnt;
    rst_n = 1'b0;
    #1;
    chk("arst_state",  32'(game_state), 32'(S_IDLE));
    chk("arst_freeze", 32'(freeze), 32'd1);
    chk("arst_dir",    32'(pacman_cur_dir), 32'h1);
    chk("arst_lives",  32'(lives), 32'd3);
    chk("arst_frame",  32'(death_frame), 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk("arst_idle",     32'(game_state), 32'(S_IDLE));
    chk("arst_no_rr",    32'(rr_cnt - rr_base), 32'd0);
    chk("arst_no_mr",    32'(mr_cnt - mr_base), 32'd0);
    chk("no_rr_in_play", 32'(rr_in_play), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
